// File: rtl/wb_pool_engine.sv
// wb_pool_engine: Wishbone slave that 2x2-pools a packed 8-bit image held in an internal buffer.
// Build option: define POOL_MAX_EN to implement the CTRL.MODE bit (runtime max pooling); otherwise average only.
module wb_pool_engine #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned PIX_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_we,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_irq
);

  localparam int unsigned IN_WORDS  = (IMG_W * IMG_H) / 4;
  localparam int unsigned OUT_W     = IMG_W / 2;
  localparam int unsigned OUT_H     = IMG_H / 2;
  localparam int unsigned OUT_WORDS = OUT_W * OUT_H;
  localparam int unsigned IN_AW     = (IN_WORDS  > 1) ? $clog2(IN_WORDS)  : 1;
  localparam int unsigned OUT_AW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int unsigned CW        = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RW        = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned SUM_W     = PIX_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STORE, S_FIN} state_e;

  state_e              state_q, state_d;
  logic                start_pend_q, start_pend_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          phase_q, phase_d;
  logic [RW-1:0]       r_q, r_d;
  logic [CW-1:0]       c_q, c_d;
  logic [OUT_AW-1:0]   m_q, m_d;
  logic [SUM_W-1:0]    sum_q, sum_d;

  logic [31:0]         in_mem  [IN_WORDS];
  logic [PIX_W-1:0]    out_mem [OUT_WORDS];

  logic [9:0]          bus_word;
  logic                sel_ctrl, sel_stat, sel_in, sel_out, in_hit, out_hit;
  logic                busy, req, wr_ctrl, wr_stat, out_we, mode_rd;
  logic [IN_AW-1:0]    in_idx;
  logic [OUT_AW-1:0]   out_idx;
  logic [31:0]         rd_mux;
  logic [31:0]         pix_row, pix_col, pix_idx, pix_word;
  logic [PIX_W-1:0]    pix, avg, pool_res;
  logic                unused_bits;

  // Address decode: only word offset bits [11:2] take part
  assign bus_word = i_wb_addr[11:2];
  assign sel_ctrl = (bus_word == 10'd0);
  assign sel_stat = (bus_word == 10'd1);
  assign sel_in   = (i_wb_addr[11:10] == 2'b01);
  assign sel_out  = (i_wb_addr[11:10] == 2'b10);
  assign in_hit   = sel_in  && (32'(i_wb_addr[9:2]) < IN_WORDS);
  assign out_hit  = sel_out && (32'(i_wb_addr[9:2]) < OUT_WORDS);
  assign in_idx   = IN_AW'(i_wb_addr[9:2]);
  assign out_idx  = OUT_AW'(i_wb_addr[9:2]);
  assign unused_bits = ^{i_wb_sel, i_wb_addr[31:12], i_wb_addr[1:0]};

  // Buffer accesses wait out a running job; CSRs always go through
  assign busy       = (state_q != S_IDLE);
  assign o_wb_stall = i_wb_cyc && i_wb_stb && busy && (sel_in || sel_out);
  assign req        = i_wb_cyc && i_wb_stb && !o_wb_stall && !ack_q;
  assign wr_ctrl    = req && i_wb_we && sel_ctrl;
  assign wr_stat    = req && i_wb_we && sel_stat;

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign o_irq     = done_q && irq_en_q;

  // Current window pixel: phase bit1 selects the row, bit0 the column
  always_comb begin
    pix_row  = 32'(r_q) * 2 + 32'(phase_q[1]);
    pix_col  = 32'(c_q) * 2 + 32'(phase_q[0]);
    pix_idx  = pix_row * IMG_W + pix_col;
    pix_word = in_mem[IN_AW'(pix_idx >> 2)];
    pix      = PIX_W'(pix_word >> (32'(pix_idx[1:0]) * PIX_W));
  end

  assign avg = sum_q[SUM_W-1:2];

`ifdef POOL_MAX_EN
  logic             mode_q, mode_d, job_max_q, job_max_d;
  logic [PIX_W-1:0] max_q, max_d;

  always_comb begin
    mode_d    = mode_q;
    job_max_d = job_max_q;
    max_d     = max_q;
    if (wr_ctrl) mode_d = i_wb_data[1];
    if ((state_q == S_IDLE) && start_pend_q) job_max_d = mode_q;
    if ((state_q == S_FETCH) && ((phase_q == 2'd0) || (pix > max_q))) max_d = pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      job_max_q <= 1'b0;
      max_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      job_max_q <= job_max_d;
      max_q     <= max_d;
    end
  end

  assign mode_rd  = mode_q;
  assign pool_res = job_max_q ? max_q : avg;
`else
  assign mode_rd  = 1'b0;
  assign pool_res = avg;
`endif

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)      rd_mux = {29'd0, irq_en_q, mode_rd, 1'b0};
    else if (sel_stat) rd_mux = {30'd0, done_q, busy};
    else if (in_hit)   rd_mux = in_mem[in_idx];
    else if (out_hit)  rd_mux = 32'(out_mem[out_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, bus response and window walk
  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    ack_d        = req;
    rdata_d      = '0;
    phase_d      = phase_q;
    r_d          = r_q;
    c_d          = c_q;
    m_d          = m_q;
    sum_d        = sum_q;
    out_we       = 1'b0;

    if (req && !i_wb_we) rdata_d = rd_mux;
    if (wr_ctrl) begin
      irq_en_d = i_wb_data[2];
      if (i_wb_data[0] && !busy && !start_pend_q) begin
        start_pend_d = 1'b1;
        done_d       = 1'b0;
      end
    end
    if (wr_stat && i_wb_data[1]) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_pend_q) begin
          state_d      = S_FETCH;
          start_pend_d = 1'b0;
          phase_d      = 2'd0;
          r_d          = '0;
          c_d          = '0;
          m_d          = '0;
        end
      end
      S_FETCH: begin
        phase_d = phase_q + 2'd1;
        sum_d   = (phase_q == 2'd0) ? SUM_W'(pix) : sum_q + SUM_W'(pix);
        if (phase_q == 2'd3) state_d = S_STORE;
      end
      S_STORE: begin
        out_we  = 1'b1;
        m_d     = m_q + OUT_AW'(1);
        phase_d = 2'd0;
        state_d = S_FETCH;
        if (c_q == CW'(OUT_W - 1)) begin
          c_d = '0;
          if (r_q == RW'(OUT_H - 1)) state_d = S_FIN;
          else                       r_d = r_q + RW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend_q <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      phase_q      <= '0;
      r_q          <= '0;
      c_q          <= '0;
      m_q          <= '0;
      sum_q        <= '0;
    end else begin
      start_pend_q <= start_pend_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      phase_q      <= phase_d;
      r_q          <= r_d;
      c_q          <= c_d;
      m_q          <= m_d;
      sum_q        <= sum_d;
    end
  end

  // Image buffers keep their contents across reset
  always_ff @(posedge clk) begin
    if (req && i_wb_we && in_hit) in_mem[in_idx] <= i_wb_data;
    if (out_we)                   out_mem[m_q]   <= pool_res;
  end

endmodule
